// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: request/control bundle between the pipeline stages and the stall controller
interface pipe_stall_ctrl_if #(parameter int CNT_W = 5, parameter int PERF_W = 32);
  logic stallreq_id;
  logic ex_mc_req;
  logic [CNT_W-1:0] ex_mc_len;
  logic stallreq_mem;
  logic excpt_i;
  logic [31:0] excpt_pc_i;
  logic [5:0] stall_o;
  logic flush_o;
  logic [31:0] new_pc_o;
  logic ex_mc_done_o;
  logic busy_o;
  logic [PERF_W-1:0] stall_cnt_o;
  modport master (
    output stallreq_id, ex_mc_req, ex_mc_len, stallreq_mem, excpt_i, excpt_pc_i,
    input stall_o, flush_o, new_pc_o, ex_mc_done_o, busy_o, stall_cnt_o
  );
  modport slave (
    input stallreq_id, ex_mc_req, ex_mc_len, stallreq_mem, excpt_i, excpt_pc_i,
    output stall_o, flush_o, new_pc_o, ex_mc_done_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/EX/MEM stalls and exception flushes into per-stage pipeline control
module pipe_stall_ctrl #(parameter int CNT_W = 5, parameter int PERF_W = 32) (
  input logic clk,
  input logic rst,
  pipe_stall_ctrl_if.slave bus
);
  typedef enum logic {IDLE, EX_WAIT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [PERF_W-1:0] perf;
  logic start, ex_stall, done, flush;
  logic [5:0] stall;
  always_comb begin
    flush = !rst && bus.excpt_i;
    start = state == IDLE && bus.ex_mc_req && bus.ex_mc_len != '0;
    ex_stall = start || (state == EX_WAIT && cnt != '0);
    done = !rst && !bus.excpt_i && !bus.stallreq_mem && state == EX_WAIT && cnt == '0;
    stall = (rst || bus.excpt_i) ? 6'b000000 :
            bus.stallreq_mem ? 6'b011111 :
            ex_stall ? 6'b001111 :
            bus.stallreq_id ? 6'b000111 : 6'b000000;
  end
  assign bus.stall_o = stall;
  assign bus.flush_o = flush;
  assign bus.new_pc_o = flush ? bus.excpt_pc_i : 32'h0;
  assign bus.ex_mc_done_o = done;
  assign bus.busy_o = !rst && state == EX_WAIT;
  assign bus.stall_cnt_o = rst ? '0 : perf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      perf <= '0;
    end else begin
      if (stall[0] && perf != '1) perf <= perf + 1'b1;
      if (bus.excpt_i) begin
        state <= IDLE;
        cnt <= '0;
      end else if (start) begin
        state <= EX_WAIT;
        cnt <= bus.ex_mc_len - 1'b1;
      end else if (state == EX_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scenario tests for the pipeline stall controller
module tb_pipe_stall_ctrl;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  pipe_stall_ctrl_if #(.CNT_W(5), .PERF_W(32)) bus ();
  pipe_stall_ctrl #(.CNT_W(5), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input logic id, input logic req, input logic [4:0] len,
                       input logic mem, input logic ex, input logic [31:0] pc);
    bus.stallreq_id = id;
    bus.ex_mc_req = req;
    bus.ex_mc_len = len;
    bus.stallreq_mem = mem;
    bus.excpt_i = ex;
    bus.excpt_pc_i = pc;
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(1, 1, 5'd4, 1, 1, 32'hdead_beef);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.stall_o, bus.flush_o, bus.new_pc_o, bus.ex_mc_done_o, bus.busy_o, bus.stall_cnt_o} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d stall=%b flush=%b pc=%h done=%b busy=%b cnt=%0d want all 0",
                 i, bus.stall_o, bus.flush_o, bus.new_pc_o, bus.ex_mc_done_o, bus.busy_o, bus.stall_cnt_o);
      end
      next();
    end
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.stall_cnt_o !== 32'd0 || bus.stall_o !== 6'b0) begin
      bad++;
      $display("FAIL reset_release busy=%b cnt=%0d stall=%b want 0 0 000000", bus.busy_o, bus.stall_cnt_o, bus.stall_o);
    end
    next();
  endtask

  task automatic test_id_stall;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_o !== 6'b000111) begin
      bad++;
      $display("FAIL id_stall got=%b want=000111", bus.stall_o);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_o !== 6'b0 || bus.stall_cnt_o !== 32'd1) begin
      bad++;
      $display("FAIL id_release stall=%b cnt=%0d want 000000 1", bus.stall_o, bus.stall_cnt_o);
    end
    next();
  endtask

  task automatic test_multicycle;
    // request held high through T3 to confirm it is ignored while waiting
    for (int t = 0; t < 4; t++) begin
      drive(0, 1, 5'd4, 0, 0, 0);
      @(negedge clk);
      total++;
      if (bus.stall_o !== 6'b001111 || bus.ex_mc_done_o !== 1'b0 || bus.busy_o !== (t != 0)) begin
        bad++;
        $display("FAIL mc_stall T%0d stall=%b done=%b busy=%b want 001111 0 %0d",
                 t, bus.stall_o, bus.ex_mc_done_o, bus.busy_o, t != 0);
      end
      next();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_o !== 6'b0 || bus.ex_mc_done_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL mc_done T4 stall=%b done=%b busy=%b want 000000 1 1", bus.stall_o, bus.ex_mc_done_o, bus.busy_o);
    end
    next();
    drive(0, 1, 5'd0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.ex_mc_done_o !== 1'b0 || bus.stall_cnt_o !== 32'd5 || bus.stall_o !== 6'b0) begin
      bad++;
      $display("FAIL mc_after busy=%b done=%b cnt=%0d stall=%b want 0 0 5 000000",
               bus.busy_o, bus.ex_mc_done_o, bus.stall_cnt_o, bus.stall_o);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.ex_mc_done_o !== 1'b0 || bus.stall_o !== 6'b0) begin
      bad++;
      $display("FAIL mc_len0 busy=%b done=%b stall=%b want 0 0 000000", bus.busy_o, bus.ex_mc_done_o, bus.stall_o);
    end
    next();
  endtask

  task automatic test_mem_overlap;
    logic [5:0] ws [4] = '{6'b001111, 6'b011111, 6'b011111, 6'b000000};
    logic wd [4] = '{0, 0, 0, 1};
    for (int t = 0; t < 4; t++) begin
      drive(0, t == 0, 5'd2, t == 1 || t == 2, 0, 0);
      @(negedge clk);
      total++;
      if (bus.stall_o !== ws[t] || bus.ex_mc_done_o !== wd[t]) begin
        bad++;
        $display("FAIL mem_overlap T%0d stall=%b done=%b want %b %b", t, bus.stall_o, bus.ex_mc_done_o, ws[t], wd[t]);
      end
      next();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.stall_cnt_o !== 32'd8) begin
      bad++;
      $display("FAIL mem_after busy=%b cnt=%0d want 0 8", bus.busy_o, bus.stall_cnt_o);
    end
    next();
  endtask

  task automatic test_flush;
    for (int t = 0; t < 3; t++) begin
      drive(0, t == 0, 5'd8, 0, 0, 0);
      @(negedge clk);
      total++;
      if (bus.stall_o !== 6'b001111 || bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
        bad++;
        $display("FAIL flush_pre T%0d stall=%b flush=%b pc=%h want 001111 0 0", t, bus.stall_o, bus.flush_o, bus.new_pc_o);
      end
      next();
    end
    drive(1, 0, 0, 0, 1, 32'h0000_0020);
    @(negedge clk);
    total++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20 || bus.stall_o !== 6'b0 || bus.ex_mc_done_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_T3 flush=%b pc=%h stall=%b done=%b want 1 00000020 000000 0",
               bus.flush_o, bus.new_pc_o, bus.stall_o, bus.ex_mc_done_o);
    end
    next();
    drive(0, 0, 0, 0, 0, 32'h0000_0020);
    for (int t = 4; t < 14; t++) begin
      @(negedge clk);
      total++;
      if (bus.busy_o !== 1'b0 || bus.ex_mc_done_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
        bad++;
        $display("FAIL flush_after T%0d busy=%b done=%b flush=%b pc=%h want 0 0 0 0",
                 t, bus.busy_o, bus.ex_mc_done_o, bus.flush_o, bus.new_pc_o);
      end
      next();
    end
    drive(1, 1, 5'd3, 1, 1, 32'h0000_1234);
    @(negedge clk);
    total++;
    if (bus.flush_o !== 1'b1 || bus.stall_o !== 6'b0 || bus.new_pc_o !== 32'h1234) begin
      bad++;
      $display("FAIL flush_vs_mem flush=%b stall=%b pc=%h want 1 000000 00001234", bus.flush_o, bus.stall_o, bus.new_pc_o);
    end
    next();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.stall_cnt_o !== 32'd11) begin
      bad++;
      $display("FAIL flush_cnt busy=%b cnt=%0d want 0 11", bus.busy_o, bus.stall_cnt_o);
    end
    next();
  endtask

  task automatic test_reset_mid_op;
    for (int t = 0; t < 2; t++) begin
      drive(0, t == 0, 5'd8, 0, 0, 0);
      next();
    end
    rst = 1;
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if ({bus.stall_o, bus.flush_o, bus.ex_mc_done_o, bus.busy_o, bus.stall_cnt_o} !== '0) begin
      bad++;
      $display("FAIL rst_mid stall=%b flush=%b done=%b busy=%b cnt=%0d want all 0",
               bus.stall_o, bus.flush_o, bus.ex_mc_done_o, bus.busy_o, bus.stall_cnt_o);
    end
    next();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    for (int t = 3; t < 14; t++) begin
      @(negedge clk);
      total++;
      if (bus.busy_o !== 1'b0 || bus.ex_mc_done_o !== 1'b0 || bus.stall_o !== 6'b0 || bus.stall_cnt_o !== 32'd0) begin
        bad++;
        $display("FAIL rst_mid_after T%0d busy=%b done=%b stall=%b cnt=%0d want 0 0 000000 0",
                 t, bus.busy_o, bus.ex_mc_done_o, bus.stall_o, bus.stall_cnt_o);
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_multicycle();
    test_mem_overlap();
    test_flush();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline-control block for the 5-stage MIPS core (PC/IF/ID/EX/MEM/WB). It merges stall requests from ID (operand not ready), EX (multi-cycle ops, sequenced by an internal counter) and MEM (memory wait), and exception flush requests. It drives a per-stage stall vector, flush/redirect to the PC and pipeline registers, a multi-cycle completion pulse back to EX, and a stall-cycle performance counter.

Parameters:
CNT_W, 5, width of EX multi-cycle length and internal down-counter
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
stallreq_id  in  1  ID requests stall (operand hazard)
ex_mc_req  in  1  EX begins a multi-cycle op this cycle; sampled only in IDLE
ex_mc_len  in  CNT_W  total cycles the op needs EX held; 0 = single-cycle
stallreq_mem  in  1  MEM requests stall (memory not ready)
excpt_i  in  1  exception/flush request
excpt_pc_i  in  32  redirect target for flush
stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush_o  out  1  clear all pipeline registers
new_pc_o  out  32  redirect PC, valid when flush_o=1
ex_mc_done_o  out  1  EX multi-cycle result final; EX advances at end of this cycle
busy_o  out  1  1 while FSM in EX_WAIT
stall_cnt_o  out  PERF_W  cycles with stall_o[0]=1 since reset, saturating

Behaviour:
- State: FSM {IDLE, EX_WAIT}, down-counter cnt (CNT_W), perf counter.
- rst=1: at edge state<=IDLE, cnt<=0, stall_cnt_o<=0. While rst=1, all outputs are forced 0 combinationally. Reset mid-EX_WAIT abandons the op: no ex_mc_done_o.
- stall_o, flush_o, new_pc_o, ex_mc_done_o are combinational from state, cnt and current inputs (same-cycle effect). busy_o and stall_cnt_o are registered.
- Stall encodings: ID stall 6'b000111, EX stall 6'b001111, MEM stall 6'b011111, none 6'b000000.
- Priority, highest first: excpt_i > stallreq_mem > EX stall (EX_WAIT or accepted ex_mc_req) > stallreq_id. Only the highest active encoding is driven.
- excpt_i=1 in any state:
  - Outputs: flush_o=1, new_pc_o=excpt_pc_i, stall_o=0, ex_mc_done_o=0.
  - Next: state<=IDLE, cnt<=0.
  - When flush_o=0, new_pc_o=0.
- IDLE, ex_mc_req=1, L=ex_mc_len≠0, no excpt_i:
  - EX stall asserted this cycle, or MEM stall if stallreq_mem.
  - Next: cnt<=L-1, state<=EX_WAIT.
  - L=0: request ignored, no stall, no done.
- EX_WAIT:
  - cnt≠0: EX stall (or MEM stall if stallreq_mem); cnt<=cnt-1.
  - cnt==0, stallreq_mem=0: ex_mc_done_o=1 (single-cycle pulse); stall_o=ID stall if stallreq_id, else 0; state<=IDLE.
  - cnt==0, stallreq_mem=1: MEM stall, done=0, remain in EX_WAIT (cnt holds at 0).
  - ex_mc_req is ignored.
- Timing: request at T0 with length L gives EX stall on cycles T0..T0+L-1 and ex_mc_done_o at T0+L, absent MEM stalls. Each MEM-stall cycle at cnt==0 delays done by one cycle.
- Perf counter: increments each cycle stall_o[0]=1 (pre-edge value). Saturates at all-ones.
- busy_o = (state==EX_WAIT).

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high -> all outputs 0. After release: state IDLE, stall_cnt_o=0.
- ID stall: stallreq_id=1 for 1 cycle -> stall_o=6'b000111 that cycle, 0 next; stall_cnt_o=1.
- Multi-cycle: ex_mc_req=1, ex_mc_len=4 at T0 -> stall_o=6'b001111 on T0..T3, ex_mc_done_o=1 only at T4, busy_o=1 on T1..T4. ex_mc_len=0 -> no stall, no done.
- MEM overlap: len=2 at T0, stallreq_mem=1 on T1..T2 -> stall_o=6'b011111 on T1..T2, done at T3, not T2.
- Flush mid-op: len=8 at T0, excpt_i=1 with excpt_pc_i=32'h0000_0020 at T3 -> flush_o=1, new_pc_o=32'h20, stall_o=0 at T3. IDLE at T4, no done ever. Simultaneous excpt_i with stallreq_mem -> flush wins.
- Reset mid-op: len=8 at T0, rst at T2 -> outputs 0; busy_o=0 after edge; no ex_mc_done_o.
